fir_result_buffer: RTL and testbench
====================================

FIR_RESULT_BUFFER -- requirements
Module: fir_result_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the FIR sample/coefficient width; the accumulator input width is AW = 2*WIDTH+6.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 16, meaning the signed output sample width.
REQ-003 The block SHALL have parameter SHIFT, default 15, meaning the arithmetic right-shift applied to the accumulator (Q15 coefficients); legal range 1..AW-OUT_WIDTH.
REQ-004 The block SHALL have parameter DEPTH, default 4, meaning the number of FIFO entries; legal values are powers of 2 and at least 2.
REQ-005 The block SHALL have port clk, input, width 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, width 1; reset is synchronous and active-high.
REQ-007 The block SHALL have port acc_in, input, width AW, the signed accumulator result from the FIR datapath.
REQ-008 The block SHALL have port acc_valid, input, width 1, a one-cycle strobe marking acc_in as a finished output sample.
REQ-009 The block SHALL have port out_data, output, width OUT_WIDTH, the signed sample at the FIFO head.
REQ-010 The block SHALL have port out_valid, output, width 1, high when the FIFO is not empty.
REQ-011 The block SHALL have port out_ready, input, width 1, the consumer accept signal.
REQ-012 The block SHALL have port level, output, width clog2(DEPTH)+1, the FIFO occupancy.
REQ-013 The block SHALL have port sat_flag, output, width 1, a sticky flag for saturation.
REQ-014 The block SHALL have port ovf_flag, output, width 1, a sticky flag for a dropped sample.
REQ-015 The block SHALL have port flag_clr, input, width 1, which clears both sticky flags.

Function
REQ-016 Stage 1 SHALL compute r = (acc_in + 2^(SHIFT-1)) >>> SHIFT as a signed value with round-half-up, using AW+1 bits internally so the add never wraps.
REQ-017 Stage 1 SHALL saturate r to OUT_WIDTH signed, clamping to 2^(OUT_WIDTH-1)-1 or -2^(OUT_WIDTH-1).
REQ-018 Stage 1 SHALL register the saturated value, a valid bit, and a saturation bit on each cycle where acc_valid=1.
REQ-019 The stage-1 valid bit SHALL be 0 on any cycle after one where acc_valid=0.
REQ-020 A valid stage-1 entry SHALL be pushed into the FIFO on the next edge when the FIFO is not full, or when it is full and a pop occurs on the same edge.
REQ-021 A valid stage-1 entry that meets neither condition in REQ-020 SHALL be dropped and SHALL set ovf_flag; FIFO contents SHALL be unchanged.
REQ-022 A pop SHALL occur on an edge where out_valid=1 and out_ready=1.
REQ-023 out_data SHALL be the oldest entry, and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 When the FIFO is empty, out_data SHALL be 0.
REQ-025 Latency SHALL be: acc_valid at edge n gives a push at edge n+1, and out_valid=1 after edge n+1 when the FIFO was empty.
REQ-026 The block SHALL have no bypass path.
REQ-027 A simultaneous push and pop SHALL leave level unchanged, including at level=DEPTH and at level=1.
REQ-028 level SHALL be the number of stored entries, in the range 0..DEPTH.
REQ-029 The read and write pointers SHALL wrap modulo DEPTH.
REQ-030 sat_flag SHALL be set when a saturated entry is pushed.
REQ-031 A saturated entry that is dropped SHALL set ovf_flag only, not sat_flag.
REQ-032 When flag_clr and a set event occur on the same edge, set SHALL win.
REQ-033 acc_valid SHALL be accepted on every cycle, including back-to-back cycles; the block SHALL never stall upstream.

Reset
REQ-034 While rst=1 at an edge, the block SHALL clear the FIFO, pointers and stage 1.
REQ-035 After reset, out_valid, level, sat_flag, ovf_flag and out_data SHALL all be 0.
REQ-036 Reset SHALL override acc_valid, out_ready and flag_clr.
REQ-037 A sample in flight in stage 1 during reset SHALL be discarded.

Verification
REQ-038 acc_in=163840 (5*2^15), acc_valid one cycle, out_ready=1 -> out_valid high exactly one cycle, 2 edges after the strobe, with out_data=5.
REQ-039 Rounding: acc_in=16384 -> out_data=1; acc_in=-16384 -> out_data=0; acc_in=-16385 -> out_data=-1 (0xFFFF); sat_flag stays 0.
REQ-040 Saturation: acc_in=2^31 -> out_data=0x7FFF; acc_in=-2^31 -> out_data=0x8000; sat_flag=1 until flag_clr; flag_clr plus a saturating push on the same edge -> sat_flag stays 1.
REQ-041 Overflow: out_ready=0, 6 back-to-back strobes with values 1..6 -> level=4, entries 1..4 kept, ovf_flag=1; draining then yields 1,2,3,4.
REQ-042 Full with simultaneous push/pop: level=4 and out_ready=1 during a strobe of 7 -> level stays 4, ovf_flag stays 0, and 7 is read out last.
REQ-043 rst asserted one cycle after a strobe with level=2 -> level=0, out_valid=0, and no output of the in-flight sample.

Source files
------------

// File: rtl/fir_result_buffer.sv
// FIR result buffer: rounds and saturates accumulator results, then queues them
// in a small FIFO for a ready/valid consumer. Sticky flags report saturation and
// dropped samples.
module fir_result_buffer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned SHIFT     = 15,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2*WIDTH+6-1:0]         acc_in,
    input  logic                         acc_valid,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         sat_flag,
    output logic                         ovf_flag,
    input  logic                         flag_clr
);

    localparam int unsigned AW = 2*WIDTH + 6;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned HW = AW - OUT_WIDTH + 2;
    localparam logic signed [AW:0]   ROUND      = (AW+1)'(1) << (SHIFT - 1);
    localparam logic [LW-1:0]        FULL_LEVEL = LW'(DEPTH);
    localparam logic [OUT_WIDTH-1:0] SAT_MAX    = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] SAT_MIN    = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic signed [AW:0]   acc_ext;
    logic signed [AW:0]   acc_rnd;
    logic signed [AW:0]   acc_shr;
    logic [HW-1:0]        hi_bits;
    logic                 sat_c;
    logic [OUT_WIDTH-1:0] sat_val_c;

    logic                 s1_valid;
    logic                 s1_sat;
    logic [OUT_WIDTH-1:0] s1_data;

    logic [OUT_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;

    logic                 pop_c;
    logic                 full_c;
    logic                 push_c;
    logic                 drop_c;
    logic [LW-1:0]        level_nxt;
    logic [OUT_WIDTH-1:0] head_nxt;

    // Round half-up, arithmetic shift and clamp to the output range.
    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        acc_ext = {acc_in[AW-1], acc_in};
        acc_rnd = acc_ext + ROUND;
        acc_shr = acc_rnd >>> SHIFT;
        hi_bits = acc_shr[AW:OUT_WIDTH-1];
        // Fits only when every bit above the output sign bit matches it.
        sat_c   = !((&hi_bits) || !(|hi_bits));
        if (sat_c) begin
            sat_val_c = acc_shr[AW] ? SAT_MIN : SAT_MAX;
        end else begin
            sat_val_c = acc_shr[OUT_WIDTH-1:0];
        end
    end

    // Stage-1 register: captures the converted sample on each strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sat   <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= acc_valid;
            if (acc_valid) begin
                s1_sat  <= sat_c;
                s1_data <= sat_val_c;
            end
        end
    end

    // FIFO push/pop decision and next occupancy / next head value.
    always_comb begin
        pop_c     = out_valid && out_ready;
        full_c    = (level == FULL_LEVEL);
        push_c    = s1_valid && (!full_c || pop_c);
        drop_c    = s1_valid && !push_c;
        level_nxt = level;
        if (push_c && !pop_c) begin
            level_nxt = level + LW'(1);
        end else if (pop_c && !push_c) begin
            level_nxt = level - LW'(1);
        end
        // The head is registered, so work out what it becomes after this edge.
        if (level_nxt == '0) begin
            head_nxt = '0;
        end else if (pop_c) begin
            head_nxt = (level == LW'(1)) ? s1_data : mem[rd_ptr + PW'(1)];
        end else if (level == '0) begin
            head_nxt = s1_data;
        end else begin
            head_nxt = out_data;
        end
    end

    // Storage array; pointers are cleared on reset so contents need no reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= s1_data;
        end
    end

    // Pointers, occupancy and registered head/valid outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            level     <= level_nxt;
            out_valid <= (level_nxt != '0);
            out_data  <= head_nxt;
        end
    end

    // Sticky flags; a set event on the same edge beats flag_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            if (push_c && s1_sat) begin
                sat_flag <= 1'b1;
            end else if (flag_clr) begin
                sat_flag <= 1'b0;
            end
            if (drop_c) begin
                ovf_flag <= 1'b1;
            end else if (flag_clr) begin
                ovf_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_result_buffer.sv
// Directed bench for fir_result_buffer with default parameters.
module tb_fir_result_buffer;

    localparam int unsigned AW = 38;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] acc_in;
    logic          acc_valid;
    logic [15:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    level;
    logic          sat_flag;
    logic          ovf_flag;
    logic          flag_clr;

    int n_tests = 0;
    int n_fail  = 0;

    fir_result_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .acc_in    (acc_in),
        .acc_valid (acc_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .sat_flag  (sat_flag),
        .ovf_flag  (ovf_flag),
        .flag_clr  (flag_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // One-cycle strobe; returns after the capturing edge.
    task automatic send(input longint v);
        acc_in    = AW'(v);
        acc_valid = 1'b1;
        step();
        acc_valid = 1'b0;
    endtask

    // Check the head, then pop it with a one-cycle ready.
    task automatic pop_check(input string tag, input logic [15:0] exp);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(exp));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; acc_in = '0; acc_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
        step(); step();
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_sat", 32'(sat_flag), 32'd0);
        check("rst_ovf", 32'(ovf_flag), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);

        // Basic latency: 5*2^15 -> 5, visible one cycle, two edges after strobe
        out_ready = 1'b1;
        send(163840);
        check("lat_nobypass", 32'(out_valid), 32'd0);
        step();
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data", 32'(out_data), 32'd5);
        check("lat_level", 32'(level), 32'd1);
        step();
        check("lat_gone", 32'(out_valid), 32'd0);
        check("lat_zero", 32'(out_data), 32'd0);
        check("lat_level0", 32'(level), 32'd0);
        out_ready = 1'b0;

        // Rounding
        send(16384);
        send(-16384);
        send(-16385);
        step();
        check("rnd_level", 32'(level), 32'd3);
        pop_check("rnd_pos", 16'd1);
        pop_check("rnd_half_neg", 16'd0);
        pop_check("rnd_neg", 16'hFFFF);
        check("rnd_sat", 32'(sat_flag), 32'd0);

        // Saturation and flag clear priority
        send(64'sd2147483648);
        step();
        check("sat_set", 32'(sat_flag), 32'd1);
        pop_check("sat_max", 16'h7FFF);
        send(-64'sd2147483648);
        step();
        pop_check("sat_min", 16'h8000);
        check("sat_sticky", 32'(sat_flag), 32'd1);
        flag_clr = 1'b1; step(); flag_clr = 1'b0;
        check("sat_clr", 32'(sat_flag), 32'd0);
        send(64'sd2147483648);
        flag_clr = 1'b1; step(); flag_clr = 1'b0;
        check("sat_set_wins", 32'(sat_flag), 32'd1);
        pop_check("sat_max2", 16'h7FFF);
        flag_clr = 1'b1; step(); flag_clr = 1'b0;
        check("sat_clr2", 32'(sat_flag), 32'd0);

        // Overflow: six strobes into a four-entry FIFO
        for (int i = 1; i <= 6; i++) send(longint'(i) <<< 15);
        step();
        check("ovf_level", 32'(level), 32'd4);
        check("ovf_flag", 32'(ovf_flag), 32'd1);
        check("ovf_nosat", 32'(sat_flag), 32'd0);
        pop_check("ovf_e1", 16'd1);
        pop_check("ovf_e2", 16'd2);
        pop_check("ovf_e3", 16'd3);
        pop_check("ovf_e4", 16'd4);
        check("ovf_empty", 32'(level), 32'd0);
        check("ovf_empty_v", 32'(out_valid), 32'd0);
        flag_clr = 1'b1; step(); flag_clr = 1'b0;
        check("ovf_clr", 32'(ovf_flag), 32'd0);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 4; i++) send(longint'(i) <<< 15);
        step();
        check("full_level", 32'(level), 32'd4);
        send(7 <<< 15);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("full_pp_level", 32'(level), 32'd4);
        check("full_pp_ovf", 32'(ovf_flag), 32'd0);
        pop_check("full_e2", 16'd2);
        pop_check("full_e3", 16'd3);
        pop_check("full_e4", 16'd4);
        pop_check("full_e7", 16'd7);
        check("full_empty", 32'(level), 32'd0);

        // Reset discards FIFO contents and the in-flight sample
        send(10 <<< 15);
        send(20 <<< 15);
        step();
        check("rst2_level_pre", 32'(level), 32'd2);
        send(30 <<< 15);
        rst = 1'b1; step(); rst = 1'b0;
        check("rst2_level", 32'(level), 32'd0);
        check("rst2_valid", 32'(out_valid), 32'd0);
        check("rst2_data", 32'(out_data), 32'd0);
        step(); step();
        check("rst2_noflight_v", 32'(out_valid), 32'd0);
        check("rst2_noflight_l", 32'(level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
